// File: rtl/fft8_unloader_pkg.sv
// Shared constants and types for the fft_8 result unloader.
package fft8_unloader_pkg;
    // Default result word: {re, im}, each half signed two's complement.
    localparam int FFT_DW     = 64;
    localparam int RE_MSB     = FFT_DW - 1;
    localparam int RE_LSB     = FFT_DW / 2;
    localparam int IM_MSB     = FFT_DW / 2 - 1;
    localparam int IM_LSB     = 0;

    // Coefficients per frame and width of the coefficient index.
    localparam int FRAME_N    = 8;
    localparam int IDX_W      = 3;

    // Inverse frames are scaled by 1/FRAME_N, i.e. an arithmetic shift.
    localparam int IFFT_SHIFT = 3;

    // Reader FSM.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rd_state_e;
endpackage

// File: rtl/fft8_unloader_if.sv
// Valid/ready result stream leaving the unloader, one coefficient per beat.
interface fft8_unloader_if
    import fft8_unloader_pkg::*;
#(
    parameter int DW = FFT_DW
);
    logic             valid;
    logic             ready;
    logic [DW-1:0]    data;
    logic [IDX_W-1:0] idx;
    logic             last;

    modport master (output valid, data, idx, last, input ready);
    modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/fft8_frame_buf.sv
// Two-entry ring of whole fft_8 frames (8 words + ifft flag each).
// The writer always has room: the launch credit check upstream guarantees it.
module fft8_frame_buf
    import fft8_unloader_pkg::*;
#(
    parameter int DW = FFT_DW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic                         wr_ifft,
    input  logic [FRAME_N-1:0][DW-1:0]   wr_data,
    input  logic                         rd_pop,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [DW-1:0]                rd_data,
    output logic                         rd_ifft,
    output logic [1:0]                   count
);
    logic [1:0][FRAME_N-1:0][DW-1:0] mem;
    logic [1:0]                      ifft_q;
    logic                            wr_ptr;
    logic                            rd_ptr;

    // Frame storage; contents are only observed while the entry is counted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr]    <= wr_data;
            ifft_q[wr_ptr] <= wr_ifft;
        end
    end

    // Ring pointers and occupancy; push and pop may land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en)  wr_ptr <= ~wr_ptr;
            if (rd_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, wr_en} - {1'b0, rd_pop};
        end
    end

    assign rd_data = mem[rd_ptr][rd_idx];
    assign rd_ifft = ifft_q[rd_ptr];
endmodule

// File: rtl/fft8_unloader.sv
// Captures parallel fft_8 results LAT cycles after each launch and
// serialises them k=0..7 onto a valid/ready stream, at most two frames
// outstanding (in flight + buffered).
module fft8_unloader
    import fft8_unloader_pkg::*;
#(
    parameter int LAT = 5,
    parameter int DW  = FFT_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  launch,
    input  logic                  launch_ifft,
    input  logic [DW-1:0]         x0,
    input  logic [DW-1:0]         x1,
    input  logic [DW-1:0]         x2,
    input  logic [DW-1:0]         x3,
    input  logic [DW-1:0]         x4,
    input  logic [DW-1:0]         x5,
    input  logic [DW-1:0]         x6,
    input  logic [DW-1:0]         x7,
    output logic                  launch_ok,
    fft8_unloader_if.master       out_if,
    output logic                  ovf
);
    localparam int H = DW / 2;

    logic [FRAME_N-1:0][DW-1:0] xin;
    logic [LAT:1]               vld_pipe;
    logic [LAT:1]               ifft_pipe;
    logic                       launch_acc;
    logic                       arrive;
    logic [3:0]                 inflight;
    logic [1:0]                 buf_cnt;
    logic [DW-1:0]              rd_word;
    logic                       rd_ifft;
    logic [H-1:0]               re_s;
    logic [H-1:0]               im_s;
    rd_state_e                  state, state_nx;
    logic [IDX_W-1:0]           k;
    logic                       hs;
    logic                       last_hs;

    assign xin        = {x7, x6, x5, x4, x3, x2, x1, x0};
    assign launch_acc = launch & launch_ok;
    assign arrive     = vld_pipe[LAT];

    // Frames still travelling through fft_8.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= LAT; i++) inflight = inflight + 4'(vld_pipe[i]);
    end

    // Credit from registered state only; a frame freed this cycle is not reusable yet.
    assign launch_ok = (inflight + {2'b00, buf_cnt}) < 4'd2;

    // Launch tracker: bit LAT is the frame whose results are on x0..x7 now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            ifft_pipe <= '0;
        end else begin
            vld_pipe[1]  <= launch_acc;
            ifft_pipe[1] <= launch_acc & launch_ifft;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                ifft_pipe[i] <= ifft_pipe[i-1];
            end
        end
    end

    // Sticky flag for launches dropped for lack of credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     ovf <= 1'b0;
        else if (launch && !launch_ok)  ovf <= 1'b1;
    end

    fft8_frame_buf #(.DW(DW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (arrive),
        .wr_ifft (ifft_pipe[LAT]),
        .wr_data (xin),
        .rd_pop  (last_hs),
        .rd_idx  (k),
        .rd_data (rd_word),
        .rd_ifft (rd_ifft),
        .count   (buf_cnt)
    );

    assign hs      = out_if.valid & out_if.ready;
    assign last_hs = hs & (k == IDX_W'(FRAME_N - 1));

    // Reader next state: an arriving frame counts as buffered so the first
    // word follows capture by one cycle, and a frame arriving on the final
    // handshake keeps SEND running without a bubble.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (buf_cnt != 2'd0 || arrive) state_nx = ST_SEND;
            ST_SEND: if (last_hs && buf_cnt == 2'd1 && !arrive) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Reader state and coefficient index; k wraps 7->0 on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            if (hs) k <= k + IDX_W'(1);
        end
    end

    // Inverse scaling: each half shifted right with sign fill, no arithmetic.
    assign re_s = {{IFFT_SHIFT{rd_word[DW-1]}}, rd_word[DW-1:H+IFFT_SHIFT]};
    assign im_s = {{IFFT_SHIFT{rd_word[H-1]}},  rd_word[H-1:IFFT_SHIFT]};

    assign out_if.valid = (state == ST_SEND);
    assign out_if.idx   = k;
    assign out_if.last  = out_if.valid & (k == IDX_W'(FRAME_N - 1));
    assign out_if.data  = !out_if.valid ? '0 :
                          rd_ifft       ? {re_s, im_s} : rd_word;
endmodule
